pico_master: RTL and testbench
==============================

PICO_MASTER -- requirements
Module: pico_master

Interface
REQ-001 Parameter ADDR_W, default 8: width of mem_addr and cmd_addr.
REQ-002 Parameter TIMEOUT, default 16: maximum BUS-state cycles without mem_ready before abort, legal range 2..255.
REQ-003 clk  input  1  single clock; all flops on its rising edge.
REQ-004 rstn  input  1  reset, asynchronous assert, active-low.
REQ-005 cmd_valid  input  1  command offered.
REQ-006 cmd_ready  output  1  command accepted when both high.
REQ-007 cmd_write  input  1  1=write, 0=read.
REQ-008 cmd_addr  input  ADDR_W  target address.
REQ-009 cmd_wdata  input  32  write data.
REQ-010 cmd_wstrb  input  4  byte enables for writes, ignored for reads.
REQ-011 rsp_valid  output  1  response available.
REQ-012 rsp_ready  input  1  response consumed when both high.
REQ-013 rsp_rdata  output  32  read data; 0 for writes and errors.
REQ-014 rsp_err  output  1  1=timeout or rejected command.
REQ-015 mem_valid  output  1  bus request to CSR slave.
REQ-016 mem_ready  input  1  slave completion strobe.
REQ-017 mem_wstrb  output  4  nonzero=write, zero=read.
REQ-018 mem_addr  output  ADDR_W  bus address.
REQ-019 mem_wdata  output  32  bus write data.
REQ-020 mem_rdata  input  32  bus read data.
REQ-021 err_count  output  8  saturating count of error responses.

Function
REQ-022 FSM states SHALL be IDLE, BUS, RESP; cmd_ready=1 only in IDLE.
REQ-023 IDLE, handshake: latch cmd fields; next state BUS, or RESP with rsp_err=1 if cmd_write=1 and cmd_wstrb=0 (no bus cycle).
REQ-024 BUS: mem_valid=1; mem_addr/mem_wdata/mem_wstrb SHALL stay constant; mem_wstrb=cmd_wstrb for writes, 4'h0 for reads; mem_wdata=0 for reads.
REQ-025 BUS, mem_ready=1: capture mem_rdata (reads) or 0 (writes) into rsp_rdata, rsp_err=0, next state RESP; mem_valid low from the next cycle.
REQ-026 BUS cycle counter SHALL start at 0 on entry; if it reaches TIMEOUT-1 with mem_ready low, next state RESP with rsp_err=1, rsp_rdata=0.
REQ-027 mem_ready sampled high on the timeout cycle SHALL win: normal completion, no error.
REQ-028 mem_ready outside BUS SHALL be ignored.
REQ-029 RESP: rsp_valid=1, rsp_rdata/rsp_err stable until rsp_ready=1; then IDLE next cycle.
REQ-030 Latency: command accepted cycle N -> mem_valid cycle N+1; ready at N+1 -> rsp_valid at N+2; minimum 3 cycles per transaction.
REQ-031 err_count SHALL increment once per error response leaving RESP, saturating at 255.

Reset
REQ-032 rstn low SHALL asynchronously force IDLE, cmd_ready=0 during reset, and rsp_valid, rsp_rdata, rsp_err, mem_valid, mem_wstrb, mem_addr, mem_wdata, err_count, counter to 0.
REQ-033 Reset mid-transaction SHALL discard the pending command without response; cmd_ready=1 on the first cycle after release.

Structure
REQ-034 Package pico_pkg SHALL hold the state enum and TIMEOUT default constant.
REQ-035 The timeout counter SHALL be a sub-module pico_timeout_ctr (clear, enable, expired outputs).

Verification
REQ-036 Read addr 8'h02, slave ready one cycle after mem_valid with rdata 32'h0000_00A5 -> rsp_rdata=32'h0000_00A5, rsp_err=0, mem_wstrb=0 throughout.
REQ-037 Write addr 8'h05 wdata 32'h1 wstrb 4'h1, ready immediately -> mem_wstrb=4'h1, rsp_valid 2 cycles after accept, rsp_err=0.
REQ-038 Read with mem_ready never asserted -> mem_valid high exactly 16 cycles, rsp_err=1, rsp_rdata=0, err_count=1.
REQ-039 Write with cmd_wstrb=0 -> no mem_valid pulse, rsp_err=1; rsp_ready held low 5 cycles -> rsp_valid and fields held.
REQ-040 Assert rstn low mid-BUS -> mem_valid=0 immediately, no response, cmd_ready=1 first cycle after release; 300 forced errors -> err_count=255.

Source files
------------

// File: rtl/pico_pkg.sv
// Shared types and defaults for the pico CSR bus master.
package pico_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int         ADDR_W_DEFAULT  = 8;
    localparam int         TIMEOUT_DEFAULT = 16;
    localparam logic [7:0] ERR_COUNT_MAX   = 8'hFF;

endpackage

// File: rtl/pico_timeout_ctr.sv
// Bus-cycle counter: cleared outside BUS, counts while enabled and flags the last
// allowed cycle before the master gives up on the slave.
module pico_timeout_ctr
    import pico_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rstn,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

    logic [7:0] count;

    // Holds at LAST so a stuck enable can never wrap back to zero.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count <= 8'h00;
        end else if (clear) begin
            count <= 8'h00;
        end else if (enable && count != LAST) begin
            count <= count + 8'h01;
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/pico_master.sv
// Single-outstanding CSR bus master: accepts one command, runs one bus cycle
// (or rejects it), and returns one response with optional timeout error.
module pico_master
    import pico_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEFAULT,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [31:0]       cmd_wdata,
    input  logic [3:0]        cmd_wstrb,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [3:0]        mem_wstrb,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic [7:0]        err_count,
    output logic [1:0]        dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; valid never waits on ready, and the payload is stable while valid.

    state_t state, state_next;
    logic   accept, reject, bus_done, bus_timeout, resp_done;
    logic   tmo_expired;

    assign cmd_ready   = rstn && (state == IDLE);
    assign mem_valid   = (state == BUS);
    assign rsp_valid   = (state == RESP);
    assign dbg_state   = state;

    assign accept      = cmd_valid && cmd_ready;
    assign reject      = accept && cmd_write && (cmd_wstrb == 4'h0);
    // A ready on the expiry cycle counts as completion, so timeout requires !mem_ready.
    assign bus_done    = (state == BUS) && mem_ready;
    assign bus_timeout = (state == BUS) && !mem_ready && tmo_expired;
    assign resp_done   = (state == RESP) && rsp_ready;

    pico_timeout_ctr #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout_ctr (
        .clk    (clk),
        .rstn   (rstn),
        .clear  (state != BUS),
        .enable (state == BUS),
        .expired(tmo_expired)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (reject) begin
                    state_next = RESP;
                end else if (accept) begin
                    state_next = BUS;
                end
            end
            BUS: begin
                if (bus_done || bus_timeout) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (resp_done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem_addr  <= '0;
            mem_wdata <= 32'h0;
            mem_wstrb <= 4'h0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
            err_count <= 8'h00;
        end else begin
            if (accept) begin
                mem_addr  <= cmd_addr;
                mem_wstrb <= cmd_write ? cmd_wstrb : 4'h0;
                mem_wdata <= cmd_write ? cmd_wdata : 32'h0;
            end
            if (reject || bus_timeout) begin
                rsp_rdata <= 32'h0;
                rsp_err   <= 1'b1;
            end else if (bus_done) begin
                rsp_rdata <= (mem_wstrb == 4'h0) ? mem_rdata : 32'h0;
                rsp_err   <= 1'b0;
            end
            if (resp_done && rsp_err && err_count != ERR_COUNT_MAX) begin
                err_count <= err_count + 8'h01;
            end
        end
    end

endmodule

// File: tb/tb_pico_master.sv
// Directed and randomized scenarios for pico_master with a response scoreboard.
module tb_pico_master;

    localparam int ADDR_W  = 8;
    localparam int TIMEOUT = 16;
    localparam int NEVER   = 1000;

    logic              clk;
    logic              rstn;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [31:0]       cmd_wdata;
    logic [3:0]        cmd_wstrb;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic              mem_valid;
    logic              mem_ready;
    logic [3:0]        mem_wstrb;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic [7:0]        err_count;
    logic [1:0]        dbg_state;

    int checks;
    int errors;
    int exp_err_cnt;
    logic [32:0] exp_q[$];

    pico_master #(
        .ADDR_W (ADDR_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr (cmd_addr),
        .cmd_wdata(cmd_wdata),
        .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .mem_valid(mem_valid),
        .mem_ready(mem_ready),
        .mem_wstrb(mem_wstrb),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .err_count(err_count),
        .dbg_state(dbg_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = 32'h0;
        cmd_wstrb = 4'h0;
        rsp_ready = 1'b0;
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
    endtask

    // Driver: one full transaction. delay = BUS cycle index on which the slave
    // answers (NEVER = no answer); hold = cycles rsp_ready stays low in RESP.
    task automatic drive_txn(input logic wr, input logic [ADDR_W-1:0] addr,
                             input logic [31:0] wdata, input logic [3:0] strb,
                             input int delay, input logic [31:0] rdata, input int hold,
                             output int mem_cycles, output int latency);
        logic        exp_e;
        logic [31:0] exp_d;
        logic [32:0] got;
        logic [3:0]  exp_ws;
        logic [31:0] exp_wd;
        int          guard;
        exp_e  = (wr && strb == 4'h0) || (!(wr && strb == 4'h0) && delay >= TIMEOUT);
        exp_d  = (exp_e || wr) ? 32'h0 : rdata;
        exp_ws = wr ? strb : 4'h0;
        exp_wd = wr ? wdata : 32'h0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_wstrb = strb;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL txn_cmd_ready got=%b exp=1", cmd_ready);
        end
        exp_q.push_back({exp_e, exp_d});
        @(negedge clk);
        cmd_valid  = 1'b0;
        cmd_wdata  = $urandom;
        latency    = 1;
        mem_cycles = 0;
        while (mem_valid === 1'b1 && mem_cycles < 40) begin
            checks++;
            if (mem_addr !== addr || mem_wstrb !== exp_ws || mem_wdata !== exp_wd) begin
                errors++;
                $display("FAIL bus_fields addr=%h/%h wstrb=%h/%h wdata=%h/%h (got/exp)",
                         mem_addr, addr, mem_wstrb, exp_ws, mem_wdata, exp_wd);
            end
            if (mem_cycles == delay) begin
                mem_ready = 1'b1;
                mem_rdata = rdata;
            end else begin
                mem_ready = 1'b0;
                mem_rdata = $urandom;
            end
            @(negedge clk);
            mem_cycles++;
            latency++;
        end
        mem_ready = 1'b0;
        guard = 0;
        while (rsp_valid !== 1'b1 && guard < 5) begin
            @(negedge clk);
            guard++;
            latency++;
        end
        checks++;
        if (rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL rsp_timeout rsp_valid=%b exp=1", rsp_valid);
            void'(exp_q.pop_front());
            return;
        end
        for (int i = 0; i < hold; i++) begin
            checks++;
            if (rsp_valid !== 1'b1 || {rsp_err, rsp_rdata} !== exp_q[0]) begin
                errors++;
                $display("FAIL rsp_hold valid=%b resp=%h exp=%h", rsp_valid,
                         {rsp_err, rsp_rdata}, exp_q[0]);
            end
            @(negedge clk);
        end
        // Scoreboard pop at the response handshake
        rsp_ready = 1'b1;
        got = exp_q.pop_front();
        checks++;
        if ({rsp_err, rsp_rdata} !== got) begin
            errors++;
            $display("FAIL rsp_data got err=%b rdata=%h exp err=%b rdata=%h",
                     rsp_err, rsp_rdata, got[32], got[31:0]);
        end
        @(negedge clk);
        rsp_ready = 1'b0;
        if (got[32] && exp_err_cnt < 255) exp_err_cnt++;
        checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || err_count !== 8'(exp_err_cnt)) begin
            errors++;
            $display("FAIL post_rsp rsp_valid=%b cmd_ready=%b err_count=%0d exp 0/1/%0d",
                     rsp_valid, cmd_ready, err_count, exp_err_cnt);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rstn = 1'b0;
        #1;
        checks++;
        if (cmd_ready !== 1'b0 || rsp_valid !== 1'b0 || mem_valid !== 1'b0 ||
            rsp_rdata !== 32'h0 || rsp_err !== 1'b0 || mem_wstrb !== 4'h0 ||
            mem_addr !== '0 || mem_wdata !== 32'h0 || err_count !== 8'h0) begin
            errors++;
            $display("FAIL reset_state rdy=%b rv=%b mv=%b rd=%h re=%b ws=%h ma=%h wd=%h ec=%0d exp all 0",
                     cmd_ready, rsp_valid, mem_valid, rsp_rdata, rsp_err, mem_wstrb,
                     mem_addr, mem_wdata, err_count);
        end
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        exp_err_cnt = 0;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || dbg_state !== 2'd0) begin
            errors++;
            $display("FAIL reset_release cmd_ready=%b state=%0d exp 1/0", cmd_ready, dbg_state);
        end
    endtask

    task automatic test_ignore_ready();
        mem_ready = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        repeat (3) @(negedge clk);
        checks++;
        if (mem_valid !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL idle_mem_ready mv=%b rv=%b rdy=%b exp 0/0/1", mem_valid, rsp_valid, cmd_ready);
        end
        mem_ready = 1'b0;
    endtask

    task automatic test_read();
        int mc, lat;
        drive_txn(1'b0, 8'h02, 32'hFFFF_FFFF, 4'hF, 1, 32'h0000_00A5, 0, mc, lat);
        checks++;
        if (mc != 2 || lat != 3) begin
            errors++;
            $display("FAIL read_timing mem_cycles=%0d latency=%0d exp 2/3", mc, lat);
        end
    endtask

    task automatic test_write();
        int mc, lat;
        drive_txn(1'b1, 8'h05, 32'h0000_0001, 4'h1, 0, 32'h1234_5678, 0, mc, lat);
        checks++;
        if (mc != 1 || lat != 2) begin
            errors++;
            $display("FAIL write_timing mem_cycles=%0d latency=%0d exp 1/2", mc, lat);
        end
    endtask

    task automatic test_timeout();
        int mc, lat;
        drive_txn(1'b0, 8'h33, 32'h0, 4'h0, NEVER, 32'hCAFE_F00D, 0, mc, lat);
        checks++;
        if (mc != TIMEOUT || err_count !== 8'd1) begin
            errors++;
            $display("FAIL timeout mem_cycles=%0d err_count=%0d exp %0d/1", mc, err_count, TIMEOUT);
        end
        // Ready on the final allowed cycle completes normally
        drive_txn(1'b0, 8'h44, 32'h0, 4'h0, TIMEOUT - 1, 32'h0BAD_F00D, 1, mc, lat);
        checks++;
        if (mc != TIMEOUT || err_count !== 8'd1) begin
            errors++;
            $display("FAIL timeout_edge mem_cycles=%0d err_count=%0d exp %0d/1", mc, err_count, TIMEOUT);
        end
    endtask

    task automatic test_reject_hold();
        int mc, lat;
        drive_txn(1'b1, 8'h07, 32'h5555_AAAA, 4'h0, 0, 32'h0, 5, mc, lat);
        checks++;
        if (mc != 0 || lat != 1 || err_count !== 8'd2) begin
            errors++;
            $display("FAIL reject mem_cycles=%0d latency=%0d err_count=%0d exp 0/1/2", mc, lat, err_count);
        end
    endtask

    task automatic test_reset_mid_bus();
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 8'h11;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (mem_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_bus_setup mem_valid=%b exp 1", mem_valid);
        end
        #2 rstn = 1'b0;
        #1;
        checks++;
        if (mem_valid !== 1'b0 || cmd_ready !== 1'b0 || rsp_valid !== 1'b0 || err_count !== 8'h0) begin
            errors++;
            $display("FAIL mid_bus_reset mv=%b rdy=%b rv=%b ec=%0d exp 0/0/0/0",
                     mem_valid, cmd_ready, rsp_valid, err_count);
        end
        exp_err_cnt = 0;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || mem_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_bus_release rdy=%b rv=%b mv=%b exp 1/0/0", cmd_ready, rsp_valid, mem_valid);
        end
    endtask

    task automatic test_err_saturate();
        int mc, lat;
        for (int i = 0; i < 300; i++) begin
            drive_txn(1'b1, 8'($urandom), $urandom, 4'h0, 0, 32'h0, 0, mc, lat);
        end
        checks++;
        if (err_count !== 8'd255) begin
            errors++;
            $display("FAIL err_saturate err_count=%0d exp 255", err_count);
        end
    endtask

    task automatic test_back_to_back();
        int mc, lat, dly, exp_mc;
        logic wr;
        logic [3:0] strb;
        for (int i = 0; i < 24; i++) begin
            wr   = 1'($urandom_range(0, 1));
            strb = 4'($urandom_range(0, 15));
            dly  = ($urandom_range(0, 5) == 0) ? NEVER : $urandom_range(0, 4);
            drive_txn(wr, 8'($urandom), $urandom, strb, dly, $urandom,
                      $urandom_range(0, 2), mc, lat);
            exp_mc = (wr && strb == 4'h0) ? 0 : ((dly >= TIMEOUT) ? TIMEOUT : dly + 1);
            checks++;
            if (mc != exp_mc) begin
                errors++;
                $display("FAIL b2b_mem_cycles txn=%0d got=%0d exp=%0d", i, mc, exp_mc);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        exp_err_cnt = 0;
        test_reset();
        test_ignore_ready();
        test_read();
        test_write();
        test_timeout();
        test_reject_hold();
        test_back_to_back();
        test_reset_mid_bus();
        test_err_saturate();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover entries=%0d exp 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
